// File: rtl/cs_uop_sequencer_pkg.sv
// Shared control-store sequencing definitions: state encodings, default widths, row count.
// Pure declarations, no latency or flow control of its own.
package cs_uop_sequencer_pkg;

  localparam int CS_ADDR_W = 7;
  localparam int CS_NU_W   = 2;
  localparam int CS_ROWS   = 1 << CS_ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    SKIP  = 2'b10
  } seq_state_e;

endpackage

// File: rtl/seq_iter_counter.sv
// REP iteration down-counter (built only with CS_SEQ_REP_EN): load wins over dec.
// Single-cycle update; is_one/is_two decode the current count.
`ifdef CS_SEQ_REP_EN
module seq_iter_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             is_one,
  output logic             is_two
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec) begin
      count <= count - CNT_W'(1);
    end
  end

  assign is_one = (count == CNT_W'(1));
  assign is_two = (count == CNT_W'(2));

endmodule
`endif

// File: rtl/cs_uop_sequencer.sv
// Control-store micro-sequencer; REP iteration and the ECX=0 SKIP row exist only with CS_SEQ_REP_EN.
// First row one cycle after accept; stall freezes everything, flush drops the instruction and blocks accept.
module cs_uop_sequencer
  import cs_uop_sequencer_pkg::*;
#(
  parameter int ADDR_W = CS_ADDR_W,
  parameter int NU_W   = CS_NU_W,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_base,
  input  logic [NU_W-1:0]   in_nuops_m1,
  input  logic              in_isREP,
  input  logic [CNT_W-1:0]  in_ecx,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_first,
  output logic              out_last,
  output logic              out_squash,
  output logic              busy
);

  seq_state_e        state_q, state_n;
  logic [ADDR_W-1:0] base_q, base_n, addr_n;
  logic [NU_W-1:0]   nrows_q, nrows_n, offset_q, offset_n;
  logic              first_iter_q, first_iter_n;
  logic              valid_n, first_n, last_n;
  logic              fire, accept, end_row, done;
  logic              iter_one, iter_two, load_one, rep_zero;

  assign fire     = out_valid & ~stall;
  assign in_ready = ~flush & ((state_q == IDLE) | (fire & out_last));
  assign accept   = in_valid & in_ready;
  assign end_row  = (offset_q == nrows_q);
  assign done     = fire & ((state_q == SKIP) | (end_row & iter_one));

`ifdef CS_SEQ_REP_EN
  assign rep_zero = in_isREP & (in_ecx == '0);
  assign load_one = ~in_isREP | (in_ecx == CNT_W'(1));

  seq_iter_counter #(.CNT_W(CNT_W)) u_iter (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val (in_isREP ? in_ecx : CNT_W'(1)),
    .dec      (fire & ~flush & (state_q == ISSUE) & end_row & ~iter_one),
    .is_one   (iter_one),
    .is_two   (iter_two)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_squash <= 1'b0;
    end else if (flush) begin
      out_squash <= 1'b0;
    end else if (accept) begin
      out_squash <= rep_zero;
    end else if (fire) begin
      out_squash <= 1'b0;
    end
  end
`else
  logic unused_rep_inputs;
  assign unused_rep_inputs = ^{in_isREP, in_ecx};
  assign rep_zero   = 1'b0;
  assign load_one   = 1'b1;
  assign iter_one   = 1'b1;
  assign iter_two   = 1'b0;
  assign out_squash = 1'b0;
`endif

  // Outputs are registered, so decode them from the next-cycle row position.
  always_comb begin
    state_n      = state_q;
    base_n       = base_q;
    nrows_n      = nrows_q;
    offset_n     = offset_q;
    first_iter_n = first_iter_q;
    valid_n      = out_valid;
    addr_n       = out_addr;
    first_n      = out_first;
    last_n       = out_last;
    if (flush) begin
      state_n = IDLE;
      valid_n = 1'b0;
      first_n = 1'b0;
      last_n  = 1'b0;
    end else if (accept) begin
      state_n      = rep_zero ? SKIP : ISSUE;
      base_n       = in_base;
      nrows_n      = in_nuops_m1;
      offset_n     = '0;
      first_iter_n = 1'b1;
      valid_n      = 1'b1;
      addr_n       = in_base;
      first_n      = 1'b1;
      last_n       = rep_zero | ((in_nuops_m1 == '0) & load_one);
    end else if (done) begin
      state_n      = IDLE;
      valid_n      = 1'b0;
      first_n      = 1'b0;
      last_n       = 1'b0;
      first_iter_n = 1'b0;
    end else if (fire) begin
      first_iter_n = 1'b0;
      first_n      = 1'b0;
      if (!end_row) begin
        offset_n = offset_q + NU_W'(1);
        last_n   = (offset_n == nrows_q) & iter_one;
      end else begin
        // Wrapping to the next iteration: the counter is about to drop by one.
        offset_n = '0;
        last_n   = (nrows_q == '0) & iter_two;
      end
      addr_n = base_q + ADDR_W'(offset_n);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      base_q       <= '0;
      nrows_q      <= '0;
      offset_q     <= '0;
      first_iter_q <= 1'b0;
      out_valid    <= 1'b0;
      out_addr     <= '0;
      out_first    <= 1'b0;
      out_last     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_n;
      base_q       <= base_n;
      nrows_q      <= nrows_n;
      offset_q     <= offset_n;
      first_iter_q <= first_iter_n;
      out_valid    <= valid_n;
      out_addr     <= addr_n;
      out_first    <= first_n;
      out_last     <= last_n;
      busy         <= (state_n != IDLE);
    end
  end

endmodule
